sram_ctrl: RTL and testbench

//  Single-port controller between the CPU memory bus and one 32-bit async SRAM bank (BaseRAM or ExtRAM).

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and default widths for the async SRAM controller.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port controller between a level req/ack bus and one 32-bit async SRAM bank.
// Every pin-side signal, including the data-drive enable, comes straight from a flop.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter  int ADDR_W  = SRAM_ADDR_W,
  parameter  int DATA_W  = SRAM_DATA_W,
  parameter  int RD_WAIT = 2,
  parameter  int WR_WAIT = 1,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              busy_o,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BE_W-1:0]   ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  // The wait counter only ever holds values up to the larger wait minus one.
  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  if (RD_WAIT < 1) begin : g_bad_rd_wait
    $error("sram_ctrl: RD_WAIT must be at least 1");
  end
  if (WR_WAIT < 1) begin : g_bad_wr_wait
    $error("sram_ctrl: WR_WAIT must be at least 1");
  end

  sram_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [BE_W-1:0]   be_n_q,  be_n_d;
  logic              ce_n_q,  ce_n_d;
  logic              oe_n_q,  oe_n_d;
  logic              we_n_q,  we_n_d;
  logic              drv_q,   drv_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q,   ack_d;

  // Next-state and next-pin values; the strobes are decided one edge ahead so they leave flops.
  always_comb begin
    // NOTE: every *_d takes its hold value first, so no branch can leave a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_n_d  = be_n_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    drv_d   = drv_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A request still high during its own ack cycle is the old one, not a new one.
        if (req_i && !ack_q) begin
          addr_d = addr_i;
          ce_n_d = 1'b0;
          if (we_i) begin
            state_d = WR_SETUP;
            be_n_d  = ~be_i;
            wdata_d = wdata_i;
            drv_d   = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
          end else begin
            state_d = RD;
            be_n_d  = '0;
            drv_d   = 1'b0;
            oe_n_d  = 1'b0;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end
        end
      end

      RD: begin
        if (cnt_q == '0) begin
          rdata_d = ram_data;
          ack_d   = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = '1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = CNT_W'(WR_WAIT - 1);
        state_d = WR_PULSE;
      end

      WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WR_HOLD: begin
        ack_d   = 1'b1;
        ce_n_d  = 1'b1;
        be_n_d  = '1;
        drv_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and pin registers; reset releases every strobe and the data bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_n_q  <= '1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drv_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drv_q   <= drv_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign ram_data = drv_q ? wdata_q : 'z;
  assign ram_addr = addr_q;
  assign ram_be_n = be_n_q;
  assign ram_ce_n = ce_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign rdata_o  = rdata_q;
  assign ack_o    = ack_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two 16-bit async SRAM halves on the pins, plus a word-level reference memory.
module tb_sram_ctrl;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [BE_W-1:0]   be = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata_o;
  logic              ack_o;
  logic              busy_o;
  wire  [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE_W-1:0]   ram_be_n;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  int n_checks   = 0;
  int n_fail     = 0;
  int acks_seen  = 0;

  // Reference memory: one whole word per address, updated by byte-mask arithmetic.
  logic [DATA_W-1:0] model [int];

  sram_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .be_i    (be),
    .wdata_i (wdata),
    .rdata_o (rdata_o),
    .ack_o   (ack_o),
    .busy_o  (busy_o),
    .ram_data(ram_data),
    .ram_addr(ram_addr),
    .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n)
  );

  always #10 clk = ~clk;

  // Async SRAM pins: low half and high half, each with two byte lanes.
  logic [15:0] mem_lo [0:(1<<ADDR_W)-1];
  logic [15:0] mem_hi [0:(1<<ADDR_W)-1];

  always @(negedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      if (!ram_be_n[0]) mem_lo[ram_addr][7:0]  <= ram_data[7:0];
      if (!ram_be_n[1]) mem_lo[ram_addr][15:8] <= ram_data[15:8];
      if (!ram_be_n[2]) mem_hi[ram_addr][7:0]  <= ram_data[23:16];
      if (!ram_be_n[3]) mem_hi[ram_addr][15:8] <= ram_data[31:24];
    end
  end

  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? {mem_hi[ram_addr], mem_lo[ram_addr]} : 'z;

  // Pin-level protocol monitor.
  logic              prev_we_low = 1'b0;
  logic              prev_ack    = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [BE_W-1:0]   prev_be_n;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    if (ack_o) acks_seen++;
    if (!rst) begin
      n_checks++;
      if (!ram_oe_n && !ram_we_n) begin
        n_fail++;
        $display("FAIL strobe_overlap: oe_n=%b we_n=%b, must not both be 0", ram_oe_n, ram_we_n);
      end
      n_checks++;
      if (ack_o && prev_ack) begin
        n_fail++;
        $display("FAIL ack_width: ack_o high two cycles running, required one-cycle pulse");
      end
      if (!ram_we_n && prev_we_low) begin
        n_checks++;
        if ({ram_addr, ram_be_n, ram_data} !== {prev_addr, prev_be_n, prev_data}) begin
          n_fail++;
          $display("FAIL we_window_stable: addr/be_n/data %h/%h/%h, required %h/%h/%h",
                   ram_addr, ram_be_n, ram_data, prev_addr, prev_be_n, prev_data);
        end
      end
    end
    prev_we_low = !ram_we_n;
    prev_ack    = ack_o;
    prev_addr   = ram_addr;
    prev_be_n   = ram_be_n;
    prev_data   = ram_data;
  end

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [BE_W-1:0]   mask);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < BE_W; k++)
      if (mask[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return '0;
  endfunction

  // One bus transaction from a negedge; checks latency, address on the pins and we_n pulse width.
  task automatic bus_op(input logic w, input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] b,
                        input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd);
    int lat;
    int we_cycles;
    int exp_lat;
    logic [ADDR_W-1:0] a_seen;
    bit got_ack;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    lat = 0; we_cycles = 0; got_ack = 1'b0; a_seen = '0;
    while (!got_ack && lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 1) a_seen = ram_addr;
      if (!ram_we_n) we_cycles++;
      if (ack_o) got_ack = 1'b1;
    end
    rd  = rdata_o;
    req = 1'b0;
    if (w) model[int'(a)] = merge(model_rd(a), d, b);
    exp_lat = w ? (WR_WAIT + 3) : (RD_WAIT + 1);
    n_checks++;
    if (!got_ack) begin
      n_fail++;
      $display("FAIL ack_timeout: no ack after %0d cycles, addr %h", lat, a);
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL latency(we=%0b): ack after %0d cycles, required %0d", w, lat, exp_lat);
    end
    n_checks++;
    if (a_seen !== a) begin
      n_fail++;
      $display("FAIL ram_addr: got %h required %h", a_seen, a);
    end
    n_checks++;
    if (we_cycles != (w ? WR_WAIT : 0)) begin
      n_fail++;
      $display("FAIL we_pulse(we=%0b): we_n low %0d cycles, required %0d", w, we_cycles, w ? WR_WAIT : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n} !== {3'b111, 4'hF}) begin
      n_fail++;
      $display("FAIL reset_strobes: ce/oe/we/be_n=%b%b%b/%h required 111/f", ram_ce_n, ram_oe_n, ram_we_n, ram_be_n);
    end
    n_checks++;
    if ({ack_o, busy_o} !== 2'b00 || rdata_o !== '0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b busy=%b rdata=%h addr=%h required all 0", ack_o, busy_o, rdata_o, ram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] rd;
    bus_op(1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, rd);
    n_checks++;
    if ({mem_hi[20'h00010], mem_lo[20'h00010]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sram_word: got %h required deadbeef", {mem_hi[20'h00010], mem_lo[20'h00010]});
    end
    bus_op(1'b0, 20'h00010, 4'h0, '0, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read: got %h required deadbeef", rd);
    end
  endtask

  task automatic test_byte_enable();
    logic [DATA_W-1:0] rd;
    bus_op(1'b1, 20'h00020, 4'hF, 32'h11223344, rd);
    bus_op(1'b1, 20'h00020, 4'b0101, 32'hAABBCCDD, rd);
    bus_op(1'b0, 20'h00020, 4'h0, '0, rd);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL byte_enable: got %h required 11bb33dd", rd);
    end
    bus_op(1'b1, 20'h00021, 4'hF, 32'h0BADF00D, rd);
    n_checks++;
    if (rdata_o !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h after a write, required 11bb33dd", rdata_o);
    end
    bus_op(1'b1, 20'h00020, 4'h0, 32'hFFFFFFFF, rd);
    bus_op(1'b0, 20'h00020, 4'h0, '0, rd);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++;
      $display("FAIL be_zero: got %h required 11bb33dd", rd);
    end
  endtask

  task automatic test_top_addr();
    logic [DATA_W-1:0] rd;
    bus_op(1'b1, 20'hFFFFF, 4'hF, 32'hA5A5C3C3, rd);
    bus_op(1'b1, 20'h00000, 4'hF, 32'h5A5A3C3C, rd);
    bus_op(1'b0, 20'hFFFFF, 4'h0, '0, rd);
    n_checks++;
    if (rd !== 32'hA5A5C3C3) begin
      n_fail++;
      $display("FAIL top_addr: got %h required a5a5c3c3", rd);
    end
    bus_op(1'b0, 20'h00000, 4'h0, '0, rd);
    n_checks++;
    if (rd !== 32'h5A5A3C3C) begin
      n_fail++;
      $display("FAIL addr_zero: got %h required 5a5a3c3c", rd);
    end
  endtask

  // req stays high across eight alternating write/read ops; only the inputs change at each ack.
  task automatic test_back_to_back();
    int ack_base;
    int lat;
    int exp_lat;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    ack_base = acks_seen;
    for (int k = 0; k < 8; k++) begin
      a  = ADDR_W'(32'h300 + k / 2);
      d  = $urandom;
      req = 1'b1; we = ~k[0]; addr = a; be = 4'hF; wdata = d;
      if (!k[0]) model[int'(a)] = d;
      if (k > 0) begin
        @(negedge clk);
        n_checks++;
        if (ack_o !== 1'b0 || busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle(op %0d): ack=%b busy=%b, required 0/0", k, ack_o, busy_o);
        end
      end
      lat = 0;
      while (!ack_o && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      exp_lat = k[0] ? (RD_WAIT + 1) : (WR_WAIT + 3);
      n_checks++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL b2b_latency(op %0d): %0d cycles, required %0d", k, lat, exp_lat);
      end
      if (k[0]) begin
        n_checks++;
        if (rdata_o !== model_rd(a)) begin
          n_fail++;
          $display("FAIL b2b_rdata(op %0d): got %h required %h", k, rdata_o, model_rd(a));
        end
      end
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (acks_seen - ack_base != 8) begin
      n_fail++;
      $display("FAIL b2b_ack_count: got %0d acks, required 8", acks_seen - ack_base);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 8; i++) bus_op(1'b1, ADDR_W'(32'h400 + i), 4'hF, $urandom, rd);
    for (int i = 0; i < 24; i++) begin
      a = ADDR_W'(32'h400 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        bus_op(1'b1, a, BE_W'($urandom_range(0, 15)), $urandom, rd);
      end else begin
        bus_op(1'b0, a, BE_W'($urandom_range(0, 15)), '0, rd);
        n_checks++;
        if (rd !== model_rd(a)) begin
          n_fail++;
          $display("FAIL random_read(addr %h): got %h required %h", a, rd, model_rd(a));
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] old_w;
    logic [DATA_W-1:0] new_w;
    int ack_base;
    int n;
    old_w = 32'h01234567;
    new_w = 32'hFEDCBA98;
    bus_op(1'b1, 20'h00500, 4'hF, old_w, rd);
    req = 1'b1; we = 1'b1; addr = 20'h00500; be = 4'hF; wdata = new_w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ram_we_n && n < 20);
    n_checks++;
    if (ram_we_n) begin
      n_fail++;
      $display("FAIL rst_mid_pulse_setup: we_n never went low");
    end
    ack_base = acks_seen;
    #2 rst = 1'b1;
    req = 1'b0;
    #1;
    n_checks++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, busy_o} !== {3'b111, 4'hF, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_pulse: ce/oe/we/be_n/busy=%b%b%b/%h/%b required 111/f/0",
               ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, busy_o);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (acks_seen != ack_base) begin
      n_fail++;
      $display("FAIL rst_no_ack: %0d acks after reset, required 0", acks_seen - ack_base);
    end
    bus_op(1'b0, 20'h00500, 4'h0, '0, rd);
    n_checks++;
    if (rd !== old_w && rd !== new_w) begin
      n_fail++;
      $display("FAIL rst_word: got %h required %h or %h", rd, old_w, new_w);
    end
    model[32'h500] = rd;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_top_addr();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
